// File: rtl/clk_div_prog.sv
// Programmable clock divider with 50% duty for odd and even divisors,
// glitch-free divisor changes at period boundaries and stop-at-boundary enable.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             div_ack,
    output logic             div_err
);

    generate
        if (DEFAULT_DIV < 2 || DEFAULT_DIV > (1 << WIDTH) - 1) begin : g_bad_default
            $error("clk_div_prog: DEFAULT_DIV out of range 2..2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] DEF_DIV = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             running_q, running_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_hi_q, clk_hi_d;
    logic             neg_q, neg_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;

    logic [WIDTH-1:0] last_cnt_s;
    logic [WIDTH-1:0] mid_cnt_s;
    logic [WIDTH:0]   half_hi_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             load_ok_s;

    // Divisor-derived thresholds: wrap point, posedge high span (ceil(D/2)), odd mid-cycle.
    always_comb begin
        last_cnt_s = div_act_q - ONE;
        mid_cnt_s  = last_cnt_s >> 1'b1;
        half_hi_s  = ({1'b0, div_act_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1'b1;
        cnt_inc_s  = cnt_q + ONE;
        load_ok_s  = (div_val > ONE);
    end

    // Next-state: period counter, start/stop, pending apply, load capture.
    always_comb begin
        running_d  = running_q;
        cnt_d      = cnt_q;
        clk_hi_d   = clk_hi_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        div_act_d  = div_act_q;

        if (!running_q) begin
            cnt_d = {WIDTH{1'b0}};
            if (en) begin
                running_d = 1'b1;
                clk_hi_d  = 1'b1;
                tick_d    = 1'b1;
                if (pend_q) begin
                    div_act_d = pend_val_q;
                    ack_d     = 1'b1;
                    pend_d    = 1'b0;
                end else begin
                    div_act_d = div_act_q;
                end
            end else begin
                clk_hi_d = 1'b0;
            end
        end else if (cnt_q == last_cnt_s) begin
            cnt_d = {WIDTH{1'b0}};
            if (en) begin
                clk_hi_d = 1'b1;
                tick_d   = 1'b1;
                // Only a value captured before this edge may switch the divisor here.
                if (pend_q) begin
                    div_act_d = pend_val_q;
                    ack_d     = 1'b1;
                    pend_d    = 1'b0;
                end else begin
                    div_act_d = div_act_q;
                end
            end else begin
                running_d = 1'b0;
                clk_hi_d  = 1'b0;
            end
        end else begin
            cnt_d    = cnt_inc_s;
            clk_hi_d = ({1'b0, cnt_inc_s} < half_hi_s);
        end

        // A load on this edge always lands in the pending slot, after any apply above.
        if (div_load) begin
            if (load_ok_s) begin
                pend_d     = 1'b1;
                pend_val_d = div_val;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // Falling-edge trim: for odd divisors, cut the high phase mid-cycle at the midpoint count.
    always_comb begin
        neg_d = running_q & div_act_q[0] & clk_hi_q & (cnt_q == mid_cnt_s);
    end

    // Posedge state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            running_q  <= 1'b0;
            cnt_q      <= {WIDTH{1'b0}};
            clk_hi_q   <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= DEF_DIV;
            div_act_q  <= DEF_DIV;
        end else begin
            running_q  <= running_d;
            cnt_q      <= cnt_d;
            clk_hi_q   <= clk_hi_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            div_act_q  <= div_act_d;
        end
    end

    // Negedge half-cycle register.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_out    = clk_hi_q & ~neg_q;
    assign tick       = tick_q;
    assign div_active = div_act_q;
    assign div_ack    = ack_q;
    assign div_err    = err_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the divisor width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 5, the divisor used after reset; it is legal for 2 <= DEFAULT_DIV <= 2^WIDTH-1, and any other value is an elaboration error.
REQ-003 SHALL have clk_in  input  1  the single clock; logic updates on its posedge, and only the odd-divisor half-cycle register uses its negedge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have en  input  1  run request.
REQ-006 SHALL have div_val  input  WIDTH  requested divisor D.
REQ-007 SHALL have div_load  input  1  captures div_val on the posedge where it is high.
REQ-008 SHALL have clk_out  output  1  divided clock.
REQ-009 SHALL have tick  output  1  one-cycle pulse on each posedge that starts an output period.
REQ-010 SHALL have div_active  output  WIDTH  divisor currently in effect.
REQ-011 SHALL have div_ack  output  1  one-cycle pulse when a pending divisor becomes active.
REQ-012 SHALL have div_err  output  1  one-cycle pulse, the cycle after a rejected load.

Function
REQ-013 SHALL keep the period counter cnt in the range 0..D_act-1, increment it on each running posedge, and wrap it from D_act-1 to 0 (the period boundary).
REQ-014 SHALL raise clk_out on the posedge where cnt enters 0, so clk_out has period D_act input cycles.
REQ-015 SHALL, for even D_act, hold clk_out high for exactly D_act/2 input cycles, falling on a posedge.
REQ-016 SHALL, for odd D_act, hold clk_out high for exactly D_act/2 input cycles, falling on the clk_in negedge in the middle of cycle cnt=(D_act-1)/2; this gives a 50% duty cycle.
REQ-017 SHALL keep clk_out glitch-free: exactly one rising and one falling transition per output period.
REQ-018 SHALL accept D in the range 2..2^WIDTH-1; D=0 or D=1 is rejected.
REQ-019 SHALL, on a rejected load, pulse div_err and leave both the pending and active divisors unchanged.
REQ-020 SHALL store a valid load into a pending register and set a pend flag; if a second load arrives while pend is set, the last value wins.
REQ-021 SHALL apply the pending value only at the first period boundary strictly after the capture posedge; on a boundary that coincides with the capture, the current period is finished and the new value applies one period later.
REQ-022 SHALL, on that boundary posedge, set div_active to the pending value, pulse div_ack, clear pend, and start a new period using the new D.
REQ-023 SHALL, when idle with en=1 on a posedge: set running, set cnt=0, apply any pending value (pulse div_ack), raise clk_out, and pulse tick.
REQ-024 SHALL treat en=0 as a stop request: sample it only at the cnt=D_act-1 posedge, and at that boundary clear running, keep clk_out low and cnt=0, and suppress tick; a partial period is never truncated.
REQ-025 SHALL keep clk_out=0, cnt=0 and tick=0 while idle, and still capture loads while idle.
REQ-026 SHALL keep div_active stable except at a boundary or idle start.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: cnt=0, running=0, clk_out=0, the negedge register=0, tick=0, div_ack=0, div_err=0, pend=0, div_active=DEFAULT_DIV.
REQ-028 SHALL, on a reset asserted mid-period, drop clk_out within the same cycle and discard any pending load.
REQ-029 SHALL, after rst_n deasserts, begin its first period on the first posedge with en=1.

Verification
REQ-030 SHALL cover the default divisor: reset, en=1, no load -> clk_out period of 5 cycles, high for 2.5 cycles, tick every 5 cycles, div_active=5.
REQ-031 SHALL cover an even divisor: load 6 while idle, then en=1 -> div_ack on the start posedge, and clk_out high 3 cycles / low 3 cycles for 20 periods.
REQ-032 SHALL cover a mid-period change: running at D=7, load 4 at cnt=2, then load 9 at cnt=4 -> the D=7 period completes, div_ack fires once, the next period is 9 cycles with high time 4.5, and 4 is never applied.
REQ-033 SHALL cover rejected loads: load 1, then load 0 -> div_err pulses each time, div_active unchanged, period unchanged, no div_ack.
REQ-034 SHALL cover stop and restart: drop en at cnt=1 with D=5 -> the full period completes, clk_out stays low with no tick; raise en -> clk_out rises on the next posedge.
REQ-035 SHALL cover reset mid-period: assert rst_n=0 while clk_out=1 with a load pending -> clk_out=0 immediately; after release, div_active=DEFAULT_DIV and no div_ack.
